// File: rtl/unified_memory_pkg.sv
// Shared definitions for unified_memory: store-size and FSM state enums, lane merge helper.
// Consumed by unified_memory and store_lane_gen.
package unified_memory_pkg;

   typedef enum logic [1:0] {
      SZ_NONE = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_WORD = 2'b11
   } store_size_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } mem_state_e;

   localparam int LANES = 4;

   // Replace the byte lanes of old_w selected by en with the matching lanes of new_w.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  en);
      logic [31:0] res;
      res = old_w;
      for (int l = 0; l < LANES; l++) begin
         if (en[l]) res[8*l +: 8] = new_w[8*l +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/unified_memory_store_lane_gen.sv
// Maps store size, low address bits and low-aligned data to byte-lane enables,
// lane-replicated data and a misalignment flag. Purely combinational.
module store_lane_gen
   import unified_memory_pkg::*;
(
   input  store_size_e i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_data,
   output logic [3:0]  o_lane_en,
   output logic [31:0] o_lane_data,
   output logic        o_misalign
);

   always_comb begin
      o_lane_en   = 4'b0000;
      o_lane_data = i_data;
      o_misalign  = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            o_lane_en   = 4'b0001 << i_addr_lo;
            o_lane_data = {4{i_data[7:0]}};
         end
         SZ_HALF: begin
            o_lane_data = {2{i_data[15:0]}};
            if (i_addr_lo[0]) o_misalign = 1'b1;
            else              o_lane_en  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         SZ_WORD: begin
            if (i_addr_lo != 2'b00) o_misalign = 1'b1;
            else                    o_lane_en  = 4'b1111;
         end
         default: begin
            o_lane_en = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/unified_memory.sv
// Dual-read, single-write unified instruction/data memory with a power-on clear sweep.
// Optional macro UNIFIED_MEMORY_BOUNDS_CHECK_EN flags and blocks out-of-range accesses.
module unified_memory
   import unified_memory_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_rd_addr,
   output logic [31:0] instr_rd_data,
   input  logic [31:0] data_rd_addr,
   output logic [31:0] data_rd_data,
   input  logic [1:0]  data_wr,
   input  logic [31:0] data_wr_addr,
   input  logic [31:0] data_wr_data,
   output logic        ready,
   output logic        err,
   output mem_state_e  o_dbg_state
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   r_mem [DEPTH_WORDS];
   mem_state_e    r_state;
   mem_state_e    w_state_nxt;
   logic [AW-1:0] r_cnt;
   logic          r_err;
   logic [31:0]   r_instr_rd_data;
   logic [31:0]   r_data_rd_data;

   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_d_idx;
   logic [AW-1:0] w_i_idx;
   logic          w_wr_oob;
   logic          w_d_oob;
   logic          w_i_oob;
   logic [3:0]    w_lane_en;
   logic [31:0]   w_lane_data;
   logic          w_misalign;
   logic          w_in_ready;
   logic          w_wr_req;
   logic          w_store_en;
   logic [3:0]    w_store_lanes;
   logic          w_err_evt;
   logic [31:0]   w_d_word;
   logic [31:0]   w_i_word;

   assign w_wr_idx = data_wr_addr[AW+1:2];
   assign w_d_idx  = data_rd_addr[AW+1:2];
   assign w_i_idx  = instr_rd_addr[AW+1:2];

`ifdef UNIFIED_MEMORY_BOUNDS_CHECK_EN
   assign w_wr_oob = |data_wr_addr[31:AW+2];
   assign w_d_oob  = |data_rd_addr[31:AW+2];
   assign w_i_oob  = |instr_rd_addr[31:AW+2];
   // Reads always return the whole word, so the byte offset is irrelevant.
   logic w_unused_addr;
   assign w_unused_addr = ^{instr_rd_addr[1:0], data_rd_addr[1:0]};
`else
   assign w_wr_oob = 1'b0;
   assign w_d_oob  = 1'b0;
   assign w_i_oob  = 1'b0;
   // Upper address bits wrap away silently when bounds checking is off.
   logic w_unused_addr;
   assign w_unused_addr = ^{instr_rd_addr[31:AW+2], instr_rd_addr[1:0],
                            data_rd_addr[31:AW+2], data_rd_addr[1:0],
                            data_wr_addr[31:AW+2]};
`endif

   store_lane_gen u_lane_gen (
      .i_size      (store_size_e'(data_wr)),
      .i_addr_lo   (data_wr_addr[1:0]),
      .i_data      (data_wr_data),
      .o_lane_en   (w_lane_en),
      .o_lane_data (w_lane_data),
      .o_misalign  (w_misalign)
   );

   assign w_in_ready    = (r_state == ST_READY);
   assign w_wr_req      = (data_wr != 2'b00);
   assign w_store_en    = w_in_ready && w_wr_req && !w_misalign && !w_wr_oob;
   assign w_store_lanes = w_store_en ? w_lane_en : 4'b0000;
   assign w_err_evt     = w_in_ready &&
                          ((w_wr_req && (w_misalign || w_wr_oob)) || w_d_oob || w_i_oob);

   // Write-first forwarding: a read of the word being stored sees the new lanes.
   assign w_d_word = merge_lanes(r_mem[w_d_idx], w_lane_data,
                                 (w_d_idx == w_wr_idx) ? w_store_lanes : 4'b0000);
   assign w_i_word = merge_lanes(r_mem[w_i_idx], w_lane_data,
                                 (w_i_idx == w_wr_idx) ? w_store_lanes : 4'b0000);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_CLEAR;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (r_cnt == AW'(DEPTH_WORDS - 1)) w_state_nxt = ST_READY;
         ST_READY: w_state_nxt = ST_READY;
         default:  w_state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                     r_cnt <= '0;
      else if (r_state == ST_CLEAR) r_cnt <= r_cnt + AW'(1);
   end

   // Storage has no reset of its own; the sweep zeroes it after every rst.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= 32'h0;
         end else begin
            for (int l = 0; l < LANES; l++) begin
               if (w_store_lanes[l]) r_mem[w_wr_idx][8*l +: 8] <= w_lane_data[8*l +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !w_in_ready) begin
         r_data_rd_data  <= 32'h0;
         r_instr_rd_data <= 32'h0;
      end else begin
         r_data_rd_data  <= w_d_oob ? 32'h0 : w_d_word;
         r_instr_rd_data <= w_i_oob ? 32'h0 : w_i_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            r_err <= 1'b0;
      else if (w_err_evt) r_err <= 1'b1;
   end

   assign instr_rd_data = r_instr_rd_data;
   assign data_rd_data  = r_data_rd_data;
   assign ready         = w_in_ready;
   assign err           = r_err;
   assign o_dbg_state   = r_state;

endmodule
